fcl1_sram_sched: RTL and testbench

Burst scheduler that shares the single-port FC-layer-1 weight SRAM between the weight loader (write requester) and the MAC engine (read requester). Grants whole bursts of BURST_LEN words and generates SRAM enables, word address and ping-pong bank select. Throttles both sides with a two-bank credit count, so reads never overtake writes and writes never overrun unread banks. Counts NEURON_CNT read bursts per layer pass and signals layer completion to the top-level FCL control.

---
 rtl/fcl1_sram_sched.sv | 144 ++++++++++++++
 tb/tb_fcl1_sram_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcl1_sram_sched.sv
// Burst scheduler for the single-port FC-layer-1 weight SRAM: arbitrates loader writes against
// MAC reads, throttled by a two-bank credit count, and tracks read bursts per layer pass.
module fcl1_sram_sched #(
  parameter int unsigned SRAM_CNT_WIDTH   = 3,
  parameter int unsigned BURST_LEN        = 5,
  parameter int unsigned NEURON_CNT       = 120,
  parameter int unsigned NEURON_CNT_WIDTH = 7
) (
  input  logic                        fcl_ctrl_clk,
  input  logic                        fcl_ctrl_rst_b,
  input  logic                        fcl1_wake_i,
  input  logic                        fcl1_restart_i,
  input  logic                        wr_req_i,
  input  logic                        rd_req_i,
  output logic                        wr_gnt_o,
  output logic                        rd_gnt_o,
  output logic                        sram_wr_en_o,
  output logic                        sram_rd_en_o,
  output logic [SRAM_CNT_WIDTH-1:0]   sram_addr_o,
  output logic                        sram_bank_o,
  output logic                        burst_done_o,
  output logic [NEURON_CNT_WIDTH-1:0] neuron_idx_o,
  output logic                        layer_done_o,
  output logic                        busy_o
);

  typedef enum logic [2:0] {StIdle, StArb, StWrBurst, StRdBurst, StDone} state_e;

  localparam logic [SRAM_CNT_WIDTH-1:0]   LastAddr   = SRAM_CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [NEURON_CNT_WIDTH-1:0] LastNeuron = NEURON_CNT_WIDTH'(NEURON_CNT);

  state_e                      state_q, state_d;
  logic [1:0]                  credits_q, credits_d;
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [NEURON_CNT_WIDTH-1:0] neuron_idx_q, neuron_idx_d;
  logic [SRAM_CNT_WIDTH-1:0]   addr_q, addr_d;
  // Set when write wins the next tie; reset favours write.
  logic                        wr_turn_q, wr_turn_d;

  logic                        wr_elig, rd_elig, last_word;
  logic [NEURON_CNT_WIDTH-1:0] neuron_inc;

  assign wr_elig    = wr_req_i & (credits_q < 2'd2);
  assign rd_elig    = rd_req_i & (credits_q != 2'd0);
  assign last_word  = (addr_q == LastAddr);
  assign neuron_inc = neuron_idx_q + NEURON_CNT_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    neuron_idx_d = neuron_idx_q;
    addr_d       = addr_q;
    wr_turn_d    = wr_turn_q;

    if (fcl1_restart_i) begin
      state_d      = StIdle;
      credits_d    = 2'd0;
      wr_bank_d    = 1'b0;
      rd_bank_d    = 1'b0;
      neuron_idx_d = '0;
      addr_d       = '0;
      wr_turn_d    = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fcl1_wake_i) state_d = StArb;
        end
        StArb: begin
          addr_d = '0;
          if (wr_elig && (!rd_elig || wr_turn_q)) begin
            state_d   = StWrBurst;
            wr_turn_d = 1'b0;
          end else if (rd_elig) begin
            state_d   = StRdBurst;
            wr_turn_d = 1'b1;
          end
        end
        StWrBurst: begin
          if (last_word) begin
            addr_d    = '0;
            credits_d = credits_q + 2'd1;
            wr_bank_d = ~wr_bank_q;
            state_d   = StArb;
          end else begin
            addr_d = addr_q + SRAM_CNT_WIDTH'(1);
          end
        end
        StRdBurst: begin
          if (last_word) begin
            addr_d       = '0;
            credits_d    = credits_q - 2'd1;
            rd_bank_d    = ~rd_bank_q;
            neuron_idx_d = neuron_inc;
            state_d      = (neuron_inc == LastNeuron) ? StDone : StArb;
          end else begin
            addr_d = addr_q + SRAM_CNT_WIDTH'(1);
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge fcl_ctrl_clk or negedge fcl_ctrl_rst_b) begin
    if (!fcl_ctrl_rst_b) begin
      state_q      <= StIdle;
      credits_q    <= 2'd0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      neuron_idx_q <= '0;
      addr_q       <= '0;
      wr_turn_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      neuron_idx_q <= neuron_idx_d;
      addr_q       <= addr_d;
      wr_turn_q    <= wr_turn_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    wr_gnt_o     = (state_q == StWrBurst);
    rd_gnt_o     = (state_q == StRdBurst);
    sram_wr_en_o = wr_gnt_o;
    sram_rd_en_o = rd_gnt_o;
    sram_addr_o  = (wr_gnt_o || rd_gnt_o) ? addr_q : '0;
    sram_bank_o  = wr_gnt_o ? wr_bank_q : (rd_gnt_o ? rd_bank_q : 1'b0);
    burst_done_o = (wr_gnt_o || rd_gnt_o) && last_word;
    neuron_idx_o = neuron_idx_q;
    layer_done_o = (state_q == StDone);
    busy_o       = (state_q != StIdle) && (state_q != StDone);
  end

endmodule

// File: tb/tb_fcl1_sram_sched.sv
// Scoreboard bench for fcl1_sram_sched: stimulus queues expected burst words, a negedge monitor
// pops and compares every granted SRAM cycle.
module tb_fcl1_sram_sched;

  localparam int unsigned BurstLen = 5;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       wake, restart, wr_req, rd_req;
  logic       wr_gnt, rd_gnt, wr_en, rd_en, bank, bdone, ldone, busy;
  logic [2:0] addr;
  logic [6:0] nidx;

  typedef struct packed {
    logic       rd;
    logic       bank;
    logic [2:0] addr;
    logic [6:0] nidx;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   en_cycles = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  fcl1_sram_sched dut (
    .fcl_ctrl_clk   (clk),
    .fcl_ctrl_rst_b (rst_b),
    .fcl1_wake_i    (wake),
    .fcl1_restart_i (restart),
    .wr_req_i       (wr_req),
    .rd_req_i       (rd_req),
    .wr_gnt_o       (wr_gnt),
    .rd_gnt_o       (rd_gnt),
    .sram_wr_en_o   (wr_en),
    .sram_rd_en_o   (rd_en),
    .sram_addr_o    (addr),
    .sram_bank_o    (bank),
    .burst_done_o   (bdone),
    .neuron_idx_o   (nidx),
    .layer_done_o   (ldone),
    .busy_o         (busy)
  );

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_burst(input logic rd, input logic bk, input int n, input int words);
    for (int a = 0; a < words; a++) begin
      exp_t e;
      e.rd   = rd;
      e.bank = bk;
      e.addr = 3'(a);
      e.nidx = 7'(n);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_b   = 1'b0;
    wake    = 1'b0;
    restart = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  function automatic int all_outs();
    return int'({wr_gnt, rd_gnt, wr_en, rd_en, addr, bank, bdone, nidx, ldone, busy});
  endfunction

  // Monitor: every granted cycle must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en || rd_en) en_cycles++;
    if (bdone) done_cnt++;
    if (wr_gnt || rd_gnt) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_grant: got wr_gnt=%0b rd_gnt=%0b bank=%0b addr=%0d, expected no grant",
                 wr_gnt, rd_gnt, bank, addr);
      end else begin
        e = exp_q.pop_front();
        check("burst_word", int'({wr_gnt, rd_gnt, bank, addr, nidx}),
              int'({~e.rd, e.rd, e.bank, e.addr, e.nidx}));
        check("burst_done_en", int'({bdone, wr_en, rd_en}),
              int'({e.addr == 3'(BurstLen - 1), ~e.rd, e.rd}));
      end
    end
  end

  initial begin
    int n;
    int en0;
    bit hit;

    // Reset values, then asynchronous reset in the middle of a write burst.
    do_reset();
    check("reset_outputs", all_outs(), 0);
    push_burst(1'b0, 1'b0, 0, 3);
    wake = 1'b1;
    wr_req = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (wr_gnt && addr == 3'd2) hit = 1;
    end
    check("wait_wr_addr2", int'(hit), 1);
    rst_b = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    wake = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("idle_after_reset", int'(busy), 0);
    check("queue_reset_mid", exp_q.size(), 0);

    // Read starvation: reads with zero credits never get the SRAM.
    en0 = en_cycles;
    wake = 1'b1;
    rd_req = 1'b1;
    repeat (30) @(negedge clk);
    check("starve_no_enable", en_cycles - en0, 0);
    check("starve_in_arb", int'(busy), 1);

    // Single write then read.
    do_reset();
    done_cnt = 0;
    push_burst(1'b0, 1'b0, 0, BurstLen);
    push_burst(1'b1, 1'b0, 0, BurstLen);
    wake = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (rd_gnt) hit = 1;
    end
    check("wait_first_read", int'(hit), 1);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (10) @(negedge clk);
    check("wr_rd_neuron_idx", int'(nidx), 1);
    check("wr_rd_done_pulses", done_cnt, 2);
    check("wr_rd_queue", exp_q.size(), 0);

    // Credit throttle: two writes fill both banks, a read frees one.
    do_reset();
    push_burst(1'b0, 1'b0, 0, BurstLen);
    push_burst(1'b0, 1'b1, 0, BurstLen);
    wake = 1'b1;
    wr_req = 1'b1;
    repeat (40) @(negedge clk);
    check("throttle_two_writes", exp_q.size(), 0);
    check("throttle_wr_gnt_low", int'(wr_gnt), 0);
    push_burst(1'b1, 1'b0, 0, BurstLen);
    push_burst(1'b0, 1'b0, 1, BurstLen);
    rd_req = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (rd_gnt) hit = 1;
    end
    check("throttle_read_gnt", int'(hit), 1);
    rd_req = 1'b0;
    repeat (20) @(negedge clk);
    check("throttle_queue", exp_q.size(), 0);
    check("throttle_neuron_idx", int'(nidx), 1);
    wr_req = 1'b0;

    // Full pass: alternating W/R, 240 bursts, DONE at first grant + 1439.
    do_reset();
    for (int j = 0; j < 120; j++) begin
      push_burst(1'b0, 1'(j % 2), j, BurstLen);
      push_burst(1'b1, 1'(j % 2), j, BurstLen);
    end
    wake = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (wr_gnt) hit = 1;
    end
    check("pass_first_grant", int'(hit), 1);
    n = 0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      n++;
      if (ldone) hit = 1;
    end
    check("pass_layer_done", int'(hit), 1);
    check("pass_cycles", n, 240 * 6 - 1);
    en0 = en_cycles;
    repeat (20) @(negedge clk);
    check("done_held", int'({ldone, busy}), 2);
    check("done_neuron_idx", int'(nidx), 120);
    check("done_ignores_req", en_cycles - en0, 0);
    check("pass_queue", exp_q.size(), 0);

    // Restart during read burst 57 at addr 3.
    do_reset();
    for (int j = 0; j < 57; j++) begin
      push_burst(1'b0, 1'(j % 2), j, BurstLen);
      push_burst(1'b1, 1'(j % 2), j, BurstLen);
    end
    push_burst(1'b0, 1'b1, 57, BurstLen);
    push_burst(1'b1, 1'b1, 57, 4);
    wake = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (rd_gnt && nidx == 7'd57 && addr == 3'd3) hit = 1;
    end
    check("wait_read57_addr3", int'(hit), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_state", int'({wr_en, rd_en, bank, busy, nidx}), 0);
    push_burst(1'b0, 1'b0, 0, BurstLen);
    n = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      n++;
      if (wr_gnt) hit = 1;
    end
    check("restart_regrant", int'(hit), 1);
    check("restart_grant_latency", n, 2);
    wr_req = 1'b0;
    rd_req = 1'b0;
    wake = 1'b0;
    repeat (15) @(negedge clk);
    check("restart_queue", exp_q.size(), 0);
    check("restart_neuron_idx", int'(nidx), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
